pixel_tx_sequencer: RTL and testbench
=====================================

// Module: pixel_tx_sequencer
// PURPOSE
//  Sequences the image-to-UART path: walks source-RAM addresses 0..NUM_PIXELS-1,
//  waits out RAM + filter latency, latches the filtered byte and hands it to the
//  UART TX FIFO with a tx_full-gated one-cycle write strobe. One pass per start
//  pulse. Sits between meminferida/bwfilter and uart inside the top level.
// PARAMETERS
//  ADDR_BITS   10    source RAM address width
//  NUM_PIXELS  1024  pixels per frame; 1..2**ADDR_BITS
//  FILTER_LAT  0     register stages inside the filter (0 = combinational)
// PORTS
//  clk       in   1          system clock
//  reset     in   1          asynchronous, active-high
//  start     in   1          1-cycle pulse; begins a frame when idle
//  abort     in   1          synchronous; ends current frame at once
//  busy      out  1          high from first READ to end of NEXT on last pixel
//  done      out  1          1-cycle pulse after last byte accepted
//  mem_addr  out  ADDR_BITS  source RAM read address
//  pix_data  in   8          filtered byte (bwfilter output)
//  tx_full   in   1          UART TX FIFO full
//  wr_uart   out  1          write strobe to UART
//  w_data    out  8          latched byte to UART
// BEHAVIOUR
//  Reset: state=IDLE, mem_addr=0, w_data=0, busy=0, done=0, wr_uart=0, counters=0.
//  States: IDLE -> READ -> WAIT -> SEND -> NEXT -> READ | IDLE.
//  IDLE: start=1 -> mem_addr<=0, READ. start while not IDLE is ignored.
//  READ: 1 cycle; mem_addr stable (held unchanged through SEND). -> WAIT.
//  WAIT: exactly 1+FILTER_LAT cycles (wcnt); w_data<=pix_data on the last
//   cycle -> SEND. Read-to-latch latency = 2+FILTER_LAT cycles.
//  SEND: wr_uart = (state==SEND) & ~tx_full, combinational from regs; exactly
//   one strobe per byte; tx_full=1 stalls indefinitely with wr_uart=0. -> NEXT
//   in the cycle after the strobe.
//  NEXT: mem_addr==NUM_PIXELS-1 -> done=1 for 1 cycle, busy=0, mem_addr<=0,
//   IDLE; else mem_addr<=mem_addr+1, READ. No wrap past NUM_PIXELS-1.
//  Min cost per pixel (tx never full): 4+FILTER_LAT cycles.
//  abort=1 in any non-IDLE state: next state IDLE, wr_uart forced 0 that cycle,
//   no done pulse, mem_addr<=0. abort has priority over start and strobes.
//  start and abort same cycle in IDLE: stay IDLE.
//  Async reset mid-frame: immediate return to reset values; no partial strobe.
// CONFIGURATION
//  GRAY3X_EN defined: each latched byte is sent 3 times (R,G,B grey) - SEND
//   repeats until rep counter 0..2 completes, each repeat its own tx_full-gated
//   strobe; 3 strobes per pixel, rep clears in NEXT and on abort/reset.
//  GRAY3X_EN undefined: one strobe per pixel; rep counter not instantiated.
// STRUCTURE
//  Shared header procseq_defs.vh: state encodings (ST_IDLE..ST_NEXT, 3 bits),
//   GRAY_REPEAT=3 constant.
//  Single module; no sub-module - counters and FSM are small and tightly coupled.
// TESTING
//  NUM_PIXELS=4, FILTER_LAT=0, tx_full=0, start -> 4 strobes, w_data = filter of
//   addr 0..3, done pulses once, busy high 16 cycles.
//  tx_full=1 for 10 cycles during SEND of pixel 1 -> wr_uart stays 0, addr held
//   at 1, exactly one strobe after release, no byte lost or duplicated.
//  abort in WAIT of pixel 2 -> IDLE next cycle, no strobe for pixel 2, done=0,
//   mem_addr=0; new start replays from addr 0.
//  GRAY3X_EN, NUM_PIXELS=2, RAM data 8'h5A,8'hC3 -> strobes 5A,5A,5A,C3,C3,C3.
//  FILTER_LAT=2 -> w_data latched 4 cycles after READ, matches filter output.
//  Async reset asserted in SEND, start pulsed while busy -> outputs at reset
//   values immediately; start while busy has no effect on sequence.

Source files
------------

// File: rtl/pixel_tx_sequencer_pkg.sv
// ============================================================================
// pixel_tx_sequencer_pkg : shared state encoding and constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package pixel_tx_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_NEXT = 3'd4
    } state_t;

    localparam int GRAY_REPEAT = 3;

    // Width of a counter that must reach max_val (never narrower than 1 bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_tx_sequencer_if.sv
// ============================================================================
// pixel_tx_sequencer_if : control, source-RAM and UART-TX signals of the sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pixel_tx_sequencer_if #(
    parameter int ADDR_BITS = 10
);
    logic                 start;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [7:0]           pix_data;
    logic                 tx_full;
    logic                 wr_uart;
    logic [7:0]           w_data;

    modport master (
        input  start, abort, pix_data, tx_full,
        output busy, done, mem_addr, wr_uart, w_data
    );

    modport slave (
        output start, abort, pix_data, tx_full,
        input  busy, done, mem_addr, wr_uart, w_data
    );
endinterface

`default_nettype wire

// File: rtl/pixel_tx_sequencer.sv
// ============================================================================
// pixel_tx_sequencer : walks source RAM, waits out RAM+filter latency, strobes
// each filtered byte into the UART TX FIFO. Define GRAY3X_EN to send every byte 3x.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pixel_tx_sequencer
    import pixel_tx_sequencer_pkg::*;
#(
    parameter int ADDR_BITS  = 10,
    parameter int NUM_PIXELS = 1024,
    parameter int FILTER_LAT = 0
) (
    input  wire logic             clk,
    input  wire logic             reset,
    pixel_tx_sequencer_if.master  bus
);

    localparam int                   WCNT_W     = cnt_width(FILTER_LAT);
    localparam logic [WCNT_W-1:0]    WCNT_LAST  = WCNT_W'(FILTER_LAT);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(NUM_PIXELS - 1);

    state_t               r_state;
    state_t               w_next;
    logic [ADDR_BITS-1:0] r_addr;
    logic [WCNT_W-1:0]    r_wcnt;
    logic [7:0]           r_data;
    logic                 r_done;

    logic                 w_strobe;
    logic                 w_send_done;
    logic                 w_wait_last;
    logic                 w_last_pix;

    assign w_wait_last = (r_state == ST_WAIT) && (r_wcnt == WCNT_LAST);
    assign w_last_pix  = (r_addr == LAST_ADDR);

    // The strobe depends only on registers and the FIFO/abort inputs, so a
    // full FIFO or an abort suppresses it within the same cycle.
    assign w_strobe = (r_state == ST_SEND) && !bus.tx_full && !bus.abort;

`ifdef GRAY3X_EN
    localparam logic [1:0] REP_LAST = 2'(GRAY_REPEAT - 1);

    logic [1:0] r_rep;

    assign w_send_done = w_strobe && (r_rep == REP_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rep <= '0;
        end else if (bus.abort || (r_state == ST_NEXT)) begin
            r_rep <= '0;
        end else if (w_strobe) begin
            r_rep <= (r_rep == REP_LAST) ? 2'd0 : r_rep + 2'd1;
        end
    end
`else
    assign w_send_done = w_strobe;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start)  w_next = ST_READ;
            ST_READ:                 w_next = ST_WAIT;
            ST_WAIT: if (w_wait_last) w_next = ST_SEND;
            ST_SEND: if (w_send_done) w_next = ST_NEXT;
            ST_NEXT:                 w_next = w_last_pix ? ST_IDLE : ST_READ;
            default:                 w_next = ST_IDLE;
        endcase
        // Abort outranks everything, including a start in IDLE.
        if (bus.abort) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wcnt <= '0;
        end else if ((r_state == ST_WAIT) && (w_next == ST_WAIT)) begin
            r_wcnt <= r_wcnt + WCNT_W'(1);
        end else begin
            r_wcnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (w_wait_last && !bus.abort) begin
            r_data <= bus.pix_data;
        end
    end

    // Address is held from READ through SEND; it only moves in NEXT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (bus.abort) begin
                r_addr <= '0;
            end else if ((r_state == ST_IDLE) && bus.start) begin
                r_addr <= '0;
            end else if (r_state == ST_NEXT) begin
                if (w_last_pix) begin
                    r_addr <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_addr <= r_addr + ADDR_BITS'(1);
                end
            end
        end
    end

    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = r_done;
    assign bus.mem_addr = r_addr;
    assign bus.wr_uart  = w_strobe;
    assign bus.w_data   = r_data;

endmodule

`default_nettype wire

// File: tb/tb_pixel_tx_sequencer.sv
// ============================================================================
// tb_pixel_tx_sequencer : checks two sequencer instances (FILTER_LAT 0 and 2)
// against a byte-stream model of RAM + filter + repeat count.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pixel_tx_sequencer;

`ifdef GRAY3X_EN
    localparam int REP = 3;
`else
    localparam int REP = 1;
`endif
    localparam int NPIX_A = 4;
    localparam int NPIX_B = 3;

    typedef logic [7:0] bq_t [$];

    typedef struct {
        logic       start;
        logic       busy;
        logic       wr;
        logic [2:0] addr;
        logic       done;
        logic       chk_data;
        logic [7:0] data;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pixel_tx_sequencer_if #(.ADDR_BITS(3)) ia ();
    pixel_tx_sequencer_if #(.ADDR_BITS(2)) ib ();

    pixel_tx_sequencer #(.ADDR_BITS(3), .NUM_PIXELS(NPIX_A), .FILTER_LAT(0)) dut_a (
        .clk(clk), .reset(reset), .bus(ia)
    );
    pixel_tx_sequencer #(.ADDR_BITS(2), .NUM_PIXELS(NPIX_B), .FILTER_LAT(2)) dut_b (
        .clk(clk), .reset(reset), .bus(ib)
    );

    // Source RAMs: 1-cycle synchronous read; B adds a 2-stage filter (xor 3C).
    logic [7:0] ram_a [0:7];
    logic [7:0] ram_b [0:3];
    logic [7:0] qa_r, qb_r, fb1, fb2;
    always @(posedge clk) begin
        qa_r <= ram_a[ia.mem_addr];
        qb_r <= ram_b[ib.mem_addr] ^ 8'h3C;
        fb1  <= qb_r;
        fb2  <= fb1;
    end
    assign ia.pix_data = qa_r;
    assign ib.pix_data = fb2;

    bq_t qa, qb;
    int  done_a = 0, done_b = 0;
    int  n_checks = 0, n_fail = 0;

    // Captures the strobe value that the following rising edge will see.
    always begin
        @(negedge clk);
        #2;
        if (ia.wr_uart) qa.push_back(ia.w_data);
        if (ib.wr_uart) qb.push_back(ib.w_data);
        if (ia.done) done_a++;
        if (ib.done) done_b++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bq_t model_a(input int npix);
        bq_t q;
        for (int p = 0; p < npix; p++)
            for (int r = 0; r < REP; r++) q.push_back(ram_a[p]);
        return q;
    endfunction

    function automatic bq_t model_b(input int npix);
        bq_t q;
        for (int p = 0; p < npix; p++)
            for (int r = 0; r < REP; r++) q.push_back(ram_b[p] ^ 8'h3C);
        return q;
    endfunction

    task automatic cmp_stream(input string name, input bq_t got, input bq_t exp);
        check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check(name, 32'(got[i]), 32'(exp[i]));
    endtask

    task automatic wait_done_a(input int budget);
        int k = 0;
        while (!ia.done && k < budget) begin @(negedge clk); k++; end
        check("done_a_seen", 32'(ia.done), 32'd1);
    endtask

    task automatic wait_done_b(input int budget);
        int k = 0;
        while (!ib.done && k < budget) begin @(negedge clk); k++; end
        check("done_b_seen", 32'(ib.done), 32'd1);
    endtask

    task automatic wait_addr_a(input logic [2:0] val, input int budget);
        int k = 0;
        while (!(ia.busy && ia.mem_addr == val) && k < budget) begin @(negedge clk); k++; end
        check("addr_a_reached", 32'(ia.mem_addr), 32'(val));
    endtask

    task automatic start_a();
        @(negedge clk); ia.start = 1'b1;
        @(negedge clk); ia.start = 1'b0;
    endtask

    task automatic rand_frame_a(input int budget);
        int d0 = done_a;
        int k  = 0;
        for (int i = 0; i < NPIX_A; i++) ram_a[i] = 8'($urandom);
        qa.delete();
        start_a();
        while (!ia.done && k < budget) begin
            ia.tx_full = ($urandom_range(0, 9) < 3);
            ia.start   = ($urandom_range(0, 7) == 0);
            @(negedge clk); k++;
        end
        ia.start = 1'b0; ia.tx_full = 1'b0;
        check("rand_a_done", 32'(ia.done), 32'd1);
        repeat (2) @(negedge clk);
        check("rand_a_done_cnt", 32'(done_a - d0), 32'd1);
        cmp_stream("rand_a_stream", qa, model_a(NPIX_A));
    endtask

    task automatic rand_frame_b(input int budget);
        int d0 = done_b;
        int k  = 0;
        for (int i = 0; i < NPIX_B; i++) ram_b[i] = 8'($urandom);
        qb.delete();
        @(negedge clk); ib.start = 1'b1;
        @(negedge clk); ib.start = 1'b0;
        while (!ib.done && k < budget) begin
            ib.tx_full = ($urandom_range(0, 9) < 3);
            ib.start   = ($urandom_range(0, 7) == 0);
            @(negedge clk); k++;
        end
        ib.start = 1'b0; ib.tx_full = 1'b0;
        check("rand_b_done", 32'(ib.done), 32'd1);
        repeat (2) @(negedge clk);
        check("rand_b_done_cnt", 32'(done_b - d0), 32'd1);
        cmp_stream("rand_b_stream", qb, model_b(NPIX_B));
    endtask

    function automatic vec_t mk(input logic s, input logic b, input logic w, input logic [2:0] a,
                                input logic d, input logic c, input logic [7:0] dat);
        vec_t v;
        v.start = s; v.busy = b; v.wr = w; v.addr = a; v.done = d; v.chk_data = c; v.data = dat;
        return v;
    endfunction

    initial begin
        vec_t tbl [$];
        int   d0;
        int   busy_cycles;

        ia.start = 1'b0; ia.abort = 1'b0; ia.tx_full = 1'b0;
        ib.start = 1'b0; ib.abort = 1'b0; ib.tx_full = 1'b0;
        ram_a[0] = 8'h5A; ram_a[1] = 8'hC3; ram_a[2] = 8'h17; ram_a[3] = 8'hE8;
        for (int i = 4; i < 8; i++) ram_a[i] = 8'hFF;
        ram_b[0] = 8'h11; ram_b[1] = 8'h22; ram_b[2] = 8'h33; ram_b[3] = 8'h44;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy",  32'(ia.busy),     32'd0);
        check("rst_done",  32'(ia.done),     32'd0);
        check("rst_addr",  32'(ia.mem_addr), 32'd0);
        check("rst_wr",    32'(ia.wr_uart),  32'd0);
        check("rst_wdata", 32'(ia.w_data),   32'd0);
        check("rst_b_busy", 32'(ib.busy),    32'd0);
        reset = 1'b0;

        // Cycle table for one clean frame: READ, WAIT, SEND x REP, NEXT per pixel
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00));
        for (int p = 0; p < NPIX_A; p++) begin
            tbl.push_back(mk(1'b0, 1'b1, 1'b0, 3'(p), 1'b0, 1'b0, 8'h00));
            tbl.push_back(mk(p == 2, 1'b1, 1'b0, 3'(p), 1'b0, 1'b0, 8'h00));
            for (int r = 0; r < REP; r++)
                tbl.push_back(mk(1'b0, 1'b1, 1'b1, 3'(p), 1'b0, 1'b1, ram_a[p]));
            tbl.push_back(mk(1'b0, 1'b1, 1'b0, 3'(p), 1'b0, 1'b0, 8'h00));
        end
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h00));

        qa.delete();
        d0 = done_a;
        busy_cycles = 0;
        foreach (tbl[i]) begin
            @(negedge clk);
            check("tbl_busy", 32'(ia.busy),     32'(tbl[i].busy));
            check("tbl_wr",   32'(ia.wr_uart),  32'(tbl[i].wr));
            check("tbl_addr", 32'(ia.mem_addr), 32'(tbl[i].addr));
            check("tbl_done", 32'(ia.done),     32'(tbl[i].done));
            if (tbl[i].chk_data) check("tbl_wdata", 32'(ia.w_data), 32'(tbl[i].data));
            busy_cycles += int'(ia.busy);
            ia.start = tbl[i].start;
        end
        ia.start = 1'b0;
        check("tbl_busy_cycles", 32'(busy_cycles), 32'(NPIX_A * (3 + REP)));
        repeat (2) @(negedge clk);
        check("tbl_done_cnt", 32'(done_a - d0), 32'd1);
        cmp_stream("tbl_stream", qa, model_a(NPIX_A));

        // FIFO full for 10 cycles around pixel 1's SEND
        qa.delete();
        d0 = done_a;
        start_a();
        wait_addr_a(3'd1, 50);
        ia.tx_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_wr",   32'(ia.wr_uart),  32'd0);
            check("stall_addr", 32'(ia.mem_addr), 32'd1);
        end
        ia.tx_full = 1'b0;
        wait_done_a(200);
        repeat (2) @(negedge clk);
        check("stall_done_cnt", 32'(done_a - d0), 32'd1);
        cmp_stream("stall_stream", qa, model_a(NPIX_A));

        // Abort while waiting on pixel 2, then a clean replay
        qa.delete();
        d0 = done_a;
        start_a();
        wait_addr_a(3'd2, 50);
        @(negedge clk);
        ia.abort = 1'b1;
        @(negedge clk);
        ia.abort = 1'b0;
        check("abort_busy", 32'(ia.busy),     32'd0);
        check("abort_addr", 32'(ia.mem_addr), 32'd0);
        check("abort_wr",   32'(ia.wr_uart),  32'd0);
        check("abort_done", 32'(ia.done),     32'd0);
        repeat (2) @(negedge clk);
        check("abort_done_cnt", 32'(done_a - d0), 32'd0);
        cmp_stream("abort_stream", qa, model_a(2));
        qa.delete();
        start_a();
        wait_done_a(200);
        repeat (2) @(negedge clk);
        cmp_stream("replay_stream", qa, model_a(NPIX_A));

        // start and abort together in IDLE
        @(negedge clk); ia.start = 1'b1; ia.abort = 1'b1;
        @(negedge clk); ia.start = 1'b0; ia.abort = 1'b0;
        check("start_abort_busy0", 32'(ia.busy), 32'd0);
        @(negedge clk);
        check("start_abort_busy1", 32'(ia.busy), 32'd0);

        // FILTER_LAT=2: byte appears 4 cycles after READ
        qb.delete();
        @(negedge clk); ib.start = 1'b1;
        @(negedge clk); ib.start = 1'b0;
        check("fl2_read_busy", 32'(ib.busy),     32'd1);
        check("fl2_read_addr", 32'(ib.mem_addr), 32'd0);
        repeat (3) @(negedge clk);
        check("fl2_wdata_early", 32'(ib.w_data), 32'd0);
        @(negedge clk);
        check("fl2_wdata_lat", 32'(ib.w_data), 32'(8'h11 ^ 8'h3C));
        wait_done_b(200);
        repeat (2) @(negedge clk);
        cmp_stream("fl2_stream", qb, model_b(NPIX_B));

        // Async reset while stalled in SEND, with start pulsed while busy
        qa.delete();
        ia.tx_full = 1'b1;
        @(negedge clk); ia.start = 1'b1;
        @(negedge clk);
        @(negedge clk); ia.start = 1'b0;
        @(negedge clk);
        check("rstmid_in_send_busy", 32'(ia.busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rstmid_busy",  32'(ia.busy),     32'd0);
        check("rstmid_wr",    32'(ia.wr_uart),  32'd0);
        check("rstmid_addr",  32'(ia.mem_addr), 32'd0);
        check("rstmid_wdata", 32'(ia.w_data),   32'd0);
        check("rstmid_done",  32'(ia.done),     32'd0);
        @(negedge clk);
        reset = 1'b0;
        ia.tx_full = 1'b0;
        repeat (2) @(negedge clk);
        check("rstmid_no_strobe", 32'(qa.size()), 32'd0);
        check("rstmid_idle", 32'(ia.busy), 32'd0);
        d0 = done_a;
        start_a();
        wait_done_a(200);
        repeat (2) @(negedge clk);
        check("rstmid_replay_done", 32'(done_a - d0), 32'd1);
        cmp_stream("rstmid_replay", qa, model_a(NPIX_A));

        // Randomised frames with random FIFO backpressure
        for (int f = 0; f < 3; f++) rand_frame_a(2000);
        for (int f = 0; f < 2; f++) rand_frame_b(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
